if_fetch_unit: RTL and testbench

Instruction-fetch front end of the MIPS III pipeline: owns the PC, handshakes with instruction memory, and produces the IF-stage signals consumed by the IF/ID register: instruction, PC, PC+4, stall/flush, branch-delay-slot flag and fetch address error. It sits directly upstream of the IF/ID stage register. It also applies ID-stage branch redirects, with MIPS delay-slot semantics, and exception redirects from CP0.

---
 rtl/mips_pkg.sv | 18 +
 rtl/if_next_pc.sv | 31 +++
 rtl/if_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: architectural vectors and the fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] EXC_BASE     = 32'h8000_0180;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2,
    S_ADERR = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC priority mux: exception redirect, then pending redirect, then ID redirect, then sequential.
module if_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        exc_flush,
  input  logic [31:0] exc_target,
  input  logic        redir_pend,
  input  logic [31:0] redir_tgt,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc;
    if (exc_flush) begin
      next_pc = exc_target;
    end else if (advance && redir_pend) begin
      next_pc = redir_tgt;
    end else if (advance && id_redirect) begin
      next_pc = id_target;
    end else if (advance) begin
      next_pc = pc_add4(pc);
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS III instruction-fetch front end: PC ownership, IMEM handshake, delay-slot and
// exception redirect handling, feeding the IF/ID register.
module if_fetch_unit
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ID_Stall,
  input  logic        ID_IsBranchJump,
  input  logic        ID_Redirect,
  input  logic [31:0] ID_RedirectTarget,
  input  logic        EXC_Flush,
  input  logic [31:0] EXC_Target,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Ack,
  input  logic [31:0] IMEM_RData,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PCOut,
  output logic [31:0] IF_PCAdd4,
  output logic        IF_Stall,
  output logic        IF_Flush,
  output logic        IF_IsBDS,
  output logic        IF_EXC_AdIF
);

  fetch_state_t state, next_state;
  logic [31:0]  pc, next_pc, drain_addr, ibuf, redir_tgt;
  logic         redir_pend, bds_pend;
  logic         aligned, valid, advance;
  logic         req, stall, adif;
  logic [31:0]  instr;

  assign aligned = (pc[1:0] == 2'b00);
  assign advance = valid & ~ID_Stall & ~EXC_Flush;

  if_next_pc u_next_pc (
    .pc          (pc),
    .advance     (advance),
    .exc_flush   (EXC_Flush),
    .exc_target  (EXC_Target),
    .redir_pend  (redir_pend),
    .redir_tgt   (redir_tgt),
    .id_redirect (ID_Redirect),
    .id_target   (ID_RedirectTarget),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_VECTOR;
      drain_addr <= RESET_VECTOR;
      ibuf       <= 32'h0000_0000;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0000_0000;
      bds_pend   <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      // The outstanding request keeps its old address while draining.
      if (EXC_Flush && (state == S_FETCH)) begin
        drain_addr <= pc;
      end
      if ((state == S_FETCH) && aligned && IMEM_Ack && ID_Stall && !EXC_Flush) begin
        ibuf <= IMEM_RData;
      end
      if (EXC_Flush || advance) begin
        redir_pend <= 1'b0;
        bds_pend   <= 1'b0;
      end else begin
        if (ID_Redirect && !ID_Stall && !redir_pend) begin
          redir_pend <= 1'b1;
          redir_tgt  <= ID_RedirectTarget;
        end
        if (ID_IsBranchJump && !ID_Stall) begin
          bds_pend <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    if (EXC_Flush) begin
      case (state)
        S_FETCH: next_state = (aligned && !IMEM_Ack) ? S_DRAIN : S_FETCH;
        S_DRAIN: next_state = IMEM_Ack ? S_FETCH : S_DRAIN;
        default: next_state = S_FETCH;
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (aligned) begin
            next_state = (IMEM_Ack && ID_Stall) ? S_HOLD : S_FETCH;
          end else begin
            next_state = advance ? S_ADERR : S_FETCH;
          end
        end
        S_HOLD:  next_state = advance ? S_FETCH : S_HOLD;
        S_DRAIN: next_state = IMEM_Ack ? S_FETCH : S_DRAIN;
        S_ADERR: next_state = S_ADERR;
        default: next_state = S_FETCH;
      endcase
    end
  end

  always_comb begin
    req   = 1'b0;
    valid = 1'b0;
    stall = 1'b1;
    adif  = 1'b0;
    instr = 32'h0000_0000;
    case (state)
      S_FETCH: begin
        if (aligned) begin
          req   = 1'b1;
          valid = IMEM_Ack;
          stall = ~IMEM_Ack;
          instr = IMEM_Ack ? IMEM_RData : 32'h0000_0000;
        end else begin
          valid = 1'b1;
          stall = 1'b0;
          adif  = 1'b1;
        end
      end
      S_HOLD: begin
        valid = 1'b1;
        stall = 1'b0;
        instr = ibuf;
      end
      S_DRAIN: req = 1'b1;
      S_ADERR: req = 1'b0;
      default: req = 1'b0;
    endcase
  end

  // Reset forces the idle/bubble view regardless of the state register contents.
  assign IMEM_Req       = ~reset & req;
  assign IMEM_Addr      = (state == S_DRAIN) ? drain_addr : pc;
  assign IF_Instruction = reset ? 32'h0000_0000 : instr;
  assign IF_PCOut       = pc;
  assign IF_PCAdd4      = pc_add4(pc);
  assign IF_Stall       = reset | stall;
  assign IF_Flush       = ~reset & (EXC_Flush | (state == S_DRAIN));
  assign IF_IsBDS       = ~reset & (bds_pend | ID_IsBranchJump);
  assign IF_EXC_AdIF    = ~reset & adif;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand sequences, and a
// randomized run against a behavioural reference model of the fetch rules.
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ID_Stall, ID_IsBranchJump, ID_Redirect, EXC_Flush;
  logic [31:0] ID_RedirectTarget, EXC_Target;
  logic        IMEM_Req, IMEM_Ack;
  logic [31:0] IMEM_Addr, IMEM_RData;
  logic [31:0] IF_Instruction, IF_PCOut, IF_PCAdd4;
  logic        IF_Stall, IF_Flush, IF_IsBDS, IF_EXC_AdIF;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  if_fetch_unit dut (
    .clock(clock), .reset(reset),
    .ID_Stall(ID_Stall), .ID_IsBranchJump(ID_IsBranchJump),
    .ID_Redirect(ID_Redirect), .ID_RedirectTarget(ID_RedirectTarget),
    .EXC_Flush(EXC_Flush), .EXC_Target(EXC_Target),
    .IMEM_Req(IMEM_Req), .IMEM_Addr(IMEM_Addr),
    .IMEM_Ack(IMEM_Ack), .IMEM_RData(IMEM_RData),
    .IF_Instruction(IF_Instruction), .IF_PCOut(IF_PCOut), .IF_PCAdd4(IF_PCAdd4),
    .IF_Stall(IF_Stall), .IF_Flush(IF_Flush), .IF_IsBDS(IF_IsBDS),
    .IF_EXC_AdIF(IF_EXC_AdIF)
  );

  // Reference model: what the fetch front end holds, in plain terms.
  logic [31:0] m_pc, m_buf, m_drain_addr, m_rt;
  bit          m_has_buf, m_draining, m_dead, m_rp, m_bp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_fetching();
    return !m_dead && !m_draining && !m_has_buf && (m_pc[1:0] == 2'b00);
  endfunction

  function automatic bit m_misaligned_shown();
    return !m_dead && !m_draining && !m_has_buf && (m_pc[1:0] != 2'b00);
  endfunction

  function automatic bit m_valid();
    return m_has_buf || m_misaligned_shown() || (m_fetching() && IMEM_Ack);
  endfunction

  task automatic model_check();
    bit          e_req, e_stall, e_flush, e_adif;
    logic [31:0] e_instr;
    if (reset) begin
      chk("rst_req", {31'd0, IMEM_Req}, 32'd0);
      chk("rst_stall", {31'd0, IF_Stall}, 32'd1);
      chk("rst_flush", {31'd0, IF_Flush}, 32'd0);
      chk("rst_bds", {31'd0, IF_IsBDS}, 32'd0);
      chk("rst_adif", {31'd0, IF_EXC_AdIF}, 32'd0);
      chk("rst_instr", IF_Instruction, 32'd0);
    end else begin
      e_req   = m_draining || m_fetching();
      e_stall = !m_valid();
      e_flush = EXC_Flush || m_draining;
      e_adif  = m_misaligned_shown();
      e_instr = m_has_buf ? m_buf : ((m_fetching() && IMEM_Ack) ? IMEM_RData : 32'd0);
      chk("m_req", {31'd0, IMEM_Req}, {31'd0, e_req});
      if (e_req) chk("m_addr", IMEM_Addr, m_draining ? m_drain_addr : m_pc);
      chk("m_stall", {31'd0, IF_Stall}, {31'd0, e_stall});
      chk("m_flush", {31'd0, IF_Flush}, {31'd0, e_flush});
      chk("m_bds", {31'd0, IF_IsBDS}, {31'd0, (m_bp || ID_IsBranchJump)});
      chk("m_adif", {31'd0, IF_EXC_AdIF}, {31'd0, e_adif});
      chk("m_pc", IF_PCOut, m_pc);
      chk("m_pc4", IF_PCAdd4, m_pc + 32'd4);
      if (!e_stall) chk("m_instr", IF_Instruction, e_instr);
    end
  endtask

  task automatic model_update();
    bit adv, fetching, mis;
    adv      = m_valid() && !ID_Stall && !EXC_Flush;
    fetching = m_fetching();
    mis      = m_misaligned_shown();
    if (reset) begin
      m_pc = 32'hBFC0_0000; m_has_buf = 0; m_draining = 0; m_dead = 0; m_rp = 0; m_bp = 0;
    end else if (EXC_Flush) begin
      if (m_draining) m_draining = !IMEM_Ack;
      else if (fetching && !IMEM_Ack) begin m_draining = 1; m_drain_addr = m_pc; end
      m_pc = EXC_Target; m_rp = 0; m_bp = 0; m_has_buf = 0; m_dead = 0;
    end else begin
      if (m_draining && IMEM_Ack) m_draining = 0;
      if (adv) begin
        m_pc = m_rp ? m_rt : (ID_Redirect ? ID_RedirectTarget : m_pc + 32'd4);
        m_rp = 0; m_bp = 0; m_has_buf = 0;
        if (mis) m_dead = 1;
      end else begin
        if (fetching && IMEM_Ack && ID_Stall) begin m_has_buf = 1; m_buf = IMEM_RData; end
        if (ID_Redirect && !ID_Stall && !m_rp) begin m_rp = 1; m_rt = ID_RedirectTarget; end
        if (ID_IsBranchJump && !ID_Stall) m_bp = 1;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic next_cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic drv(input bit ack, input logic [31:0] rd, input bit ids, input bit bj,
                     input bit rdr, input logic [31:0] rtgt, input bit fl, input logic [31:0] ftgt);
    IMEM_Ack = ack; IMEM_RData = rd; ID_Stall = ids; ID_IsBranchJump = bj;
    ID_Redirect = rdr; ID_RedirectTarget = rtgt; EXC_Flush = fl; EXC_Target = ftgt;
  endtask

  typedef struct {
    bit          rst;
    bit          ack;
    logic [31:0] rdata;
    bit          ids;
    bit          ereq;
    logic [31:0] eaddr;
    bit          estall;
    logic [31:0] einstr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit          busy;
    int unsigned lat;
    tbl[0] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_0000, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h1111_1111};
    tbl[2] = '{1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'hBFC0_0004, 1'b0, 32'h2222_2222};
    tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hBFC0_0008, 1'b1, 32'h0};
    tbl[6] = '{1'b0, 1'b1, 32'h2402_0001, 1'b1, 1'b1, 32'hBFC0_0008, 1'b0, 32'h2402_0001};
    tbl[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hBFC0_0008, 1'b0, 32'h2402_0001};
    tbl[8] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'hBFC0_0008, 1'b0, 32'h2402_0001};
    tbl[9] = '{1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b1, 32'hBFC0_000C, 1'b0, 32'h3333_3333};

    reset = 1'b1;
    drv(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clock);
    next_cycle();

    // Directed vectors: reset, zero-wait, 3 wait cycles, ID stall hold and release.
    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst;
      drv(tbl[i].ack, tbl[i].rdata, tbl[i].ids, 0, 0, 32'h0, 0, 32'h0);
      settle();
      chk($sformatf("tbl%0d_req", i), {31'd0, IMEM_Req}, {31'd0, tbl[i].ereq});
      if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), IMEM_Addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_stall", i), {31'd0, IF_Stall}, {31'd0, tbl[i].estall});
      if (!tbl[i].estall) chk($sformatf("tbl%0d_instr", i), IF_Instruction, tbl[i].einstr);
      next_cycle();
    end

    // Taken branch with a delay slot that waits two cycles.
    drv(1, 32'h0, 0, 0, 0, 32'h0, 1, 32'hBFC0_0100); settle();
    chk("jmp_flush", {31'd0, IF_Flush}, 32'd1); next_cycle();
    drv(1, 32'h1000_007F, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("br_addr", IMEM_Addr, 32'hBFC0_0100); next_cycle();
    drv(0, 32'h0, 0, 1, 1, 32'hBFC0_0200, 0, 32'h0); settle();
    chk("bds_addr", IMEM_Addr, 32'hBFC0_0104); chk("bds_flag0", {31'd0, IF_IsBDS}, 32'd1); next_cycle();
    drv(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("bds_flag1", {31'd0, IF_IsBDS}, 32'd1); chk("bds_wait", {31'd0, IF_Stall}, 32'd1); next_cycle();
    drv(1, 32'h0000_0000, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("bds_flag2", {31'd0, IF_IsBDS}, 32'd1); chk("bds_pc", IF_PCOut, 32'hBFC0_0104); next_cycle();
    drv(1, 32'h2402_0005, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("tgt_addr", IMEM_Addr, 32'hBFC0_0200); chk("tgt_bds", {31'd0, IF_IsBDS}, 32'd0); next_cycle();

    // Exception while a request is outstanding: drain, then fetch the vector.
    drv(0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h8000_0180); settle();
    chk("exc_flush", {31'd0, IF_Flush}, 32'd1); chk("exc_addr0", IMEM_Addr, 32'hBFC0_0204); next_cycle();
    drv(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("drain_req", {31'd0, IMEM_Req}, 32'd1); chk("drain_addr", IMEM_Addr, 32'hBFC0_0204);
    chk("drain_flush", {31'd0, IF_Flush}, 32'd1); next_cycle();
    drv(1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("drain_ack_stall", {31'd0, IF_Stall}, 32'd1); next_cycle();
    drv(1, 32'h0000_0011, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("vec_addr", IMEM_Addr, 32'h8000_0180); chk("vec_flush", {31'd0, IF_Flush}, 32'd0); next_cycle();

    // jr to a misaligned target.
    drv(1, 32'h0060_0008, 0, 1, 1, 32'hBFC0_0202, 0, 32'h0); settle();
    chk("jr_addr", IMEM_Addr, 32'h8000_0184); next_cycle();
    drv(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("ad_flag", {31'd0, IF_EXC_AdIF}, 32'd1); chk("ad_req", {31'd0, IMEM_Req}, 32'd0);
    chk("ad_instr", IF_Instruction, 32'd0); chk("ad_pc", IF_PCOut, 32'hBFC0_0202); next_cycle();
    for (int i = 0; i < 2; i++) begin
      drv(0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0); settle();
      chk("aderr_stall", {31'd0, IF_Stall}, 32'd1); chk("aderr_req", {31'd0, IMEM_Req}, 32'd0); next_cycle();
    end
    drv(0, 32'h0, 0, 0, 0, 32'h0, 1, 32'h8000_0180); settle();
    chk("ad_exc_flush", {31'd0, IF_Flush}, 32'd1); next_cycle();
    drv(1, 32'h0000_0022, 0, 0, 0, 32'h0, 0, 32'h0); settle();
    chk("ad_vec_addr", IMEM_Addr, 32'h8000_0180); next_cycle();

    // Randomized traffic with a variable-latency memory.
    busy = 0;
    lat  = 0;
    for (int c = 0; c < 3000; c++) begin
      ID_Stall        = ($urandom_range(0, 99) < 25);
      ID_IsBranchJump = ($urandom_range(0, 99) < 15);
      ID_Redirect     = ID_IsBranchJump && $urandom_range(0, 1) == 1;
      ID_RedirectTarget = {16'hBFC0, 16'($urandom) & 16'hFFFC};
      if ($urandom_range(0, 99) < 3) ID_RedirectTarget[1] = 1'b1;
      EXC_Flush  = ($urandom_range(0, 99) < 4);
      EXC_Target = ($urandom_range(0, 1) == 1) ? 32'h8000_0180 : 32'hBFC0_0380;
      IMEM_Ack   = 1'b0;
      IMEM_RData = $urandom;
      if (IMEM_Req) begin
        if (!busy) begin busy = 1; lat = $urandom_range(0, 3); end
        if (lat == 0) begin IMEM_Ack = 1'b1; busy = 0; end
        else lat--;
      end
      settle();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
